// File: rtl/masked_aes_pkg.sv
// masked_aes_pkg: shared FSM states, slice offsets and default block width for the masked AES stream I/O.
package masked_aes_pkg;
  localparam int BLOCK_W_DEF = 128;
  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_e;
  function automatic int share_lsb(input int share, input int w);
    return share * w;
  endfunction
  // Beat 0 lands in the most-significant lane of a share.
  function automatic int lane_lsb(input int beat, input int beats, input int lane_w);
    return (beats - 1 - beat) * lane_w;
  endfunction
endpackage

// File: rtl/masked_lane_refresh.sv
// masked_lane_refresh: remasks one SHARES*LANE_W lane with fresh randomness; passes through when EN=0.
module masked_lane_refresh import masked_aes_pkg::*; #(
  parameter int SHARES = 2,
  parameter int LANE_W = 8,
  parameter bit EN     = 1'b1
) (
  input  logic [SHARES*LANE_W-1:0]     lane_i,
  input  logic [(SHARES-1)*LANE_W-1:0] rnd_i,
  output logic [SHARES*LANE_W-1:0]     lane_o
);
  logic [SHARES*LANE_W-1:0] fresh;
  logic [LANE_W-1:0]        acc;
  // Share 0 absorbs every r_j so the XOR of all shares is unchanged.
  always_comb begin
    fresh = lane_i;
    acc   = '0;
    for (int j = 1; j < SHARES; j++) begin
      fresh[share_lsb(j, LANE_W) +: LANE_W] = lane_i[share_lsb(j, LANE_W) +: LANE_W] ^ rnd_i[share_lsb(j - 1, LANE_W) +: LANE_W];
      acc = acc ^ rnd_i[share_lsb(j - 1, LANE_W) +: LANE_W];
    end
    fresh[LANE_W-1:0] = lane_i[LANE_W-1:0] ^ acc;
  end
  assign lane_o = EN ? fresh : lane_i;
endmodule

// File: rtl/masked_aes_stream_io.sv
// masked_aes_stream_io: loads shared pt/key lanes, starts the masked AES core and streams the shared result out.
// Define MASKED_IO_REMASK_EN to refresh every accepted lane with rnd_in before storage.
module masked_aes_stream_io import masked_aes_pkg::*; #(
  parameter  int SHARES  = 2,
  parameter  int LANE_W  = 8,
  parameter  int BLOCK_W = BLOCK_W_DEF,
  localparam int BEATS   = BLOCK_W / LANE_W,
  localparam int CNT_W   = $clog2(BEATS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SHARES*LANE_W-1:0]       in_pt,
  input  logic [SHARES*LANE_W-1:0]       in_key,
  input  logic [2*(SHARES-1)*LANE_W-1:0] rnd_in,
  output logic                           core_go,
  output logic [SHARES*BLOCK_W-1:0]      core_pt,
  output logic [SHARES*BLOCK_W-1:0]      core_key,
  input  logic [SHARES*BLOCK_W-1:0]      core_out,
  input  logic                           core_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SHARES*LANE_W-1:0]       out_data,
  output logic                           out_last,
  output logic                           busy
);
`ifdef MASKED_IO_REMASK_EN
  localparam bit REMASK_EN = 1'b1;
`else
  localparam bit REMASK_EN = 1'b0;
`endif
  localparam int RW = (SHARES - 1) * LANE_W;
  logic [SHARES*LANE_W-1:0]  pt_lane, key_lane;
  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SHARES*BLOCK_W-1:0] pt_q, pt_d, key_q, key_d, out_q, out_d;
  logic                      last;
  masked_lane_refresh #(.SHARES(SHARES), .LANE_W(LANE_W), .EN(REMASK_EN)) u_pt_refresh (
    .lane_i(in_pt), .rnd_i(rnd_in[RW-1:0]), .lane_o(pt_lane)
  );
  masked_lane_refresh #(.SHARES(SHARES), .LANE_W(LANE_W), .EN(REMASK_EN)) u_key_refresh (
    .lane_i(in_key), .rnd_i(rnd_in[2*RW-1:RW]), .lane_o(key_lane)
  );
  assign last = cnt_q == CNT_W'(BEATS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    key_d   = key_q;
    out_d   = out_q;
    case (state_q)
      LOAD: if (in_valid) begin
        for (int s = 0; s < SHARES; s++) begin
          pt_d[share_lsb(s, BLOCK_W) + lane_lsb(int'(cnt_q), BEATS, LANE_W) +: LANE_W]  = pt_lane[share_lsb(s, LANE_W) +: LANE_W];
          key_d[share_lsb(s, BLOCK_W) + lane_lsb(int'(cnt_q), BEATS, LANE_W) +: LANE_W] = key_lane[share_lsb(s, LANE_W) +: LANE_W];
        end
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? START : LOAD;
      end
      START: state_d = WAIT;
      WAIT: if (core_done) begin
        out_d   = core_out;
        state_d = UNLOAD;
      end
      UNLOAD: if (out_ready) begin
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? LOAD : UNLOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end
  always_comb begin
    out_data = '0;
    for (int s = 0; s < SHARES; s++)
      out_data[share_lsb(s, LANE_W) +: LANE_W] = out_q[share_lsb(s, BLOCK_W) + lane_lsb(int'(cnt_q), BEATS, LANE_W) +: LANE_W];
  end
  assign in_ready  = state_q == LOAD;
  assign core_go   = state_q == START;
  assign out_valid = state_q == UNLOAD;
  assign out_last  = out_valid && last;
  assign busy      = !in_ready;
  assign core_pt   = pt_q;
  assign core_key  = key_q;
endmodule

// File: tb/tb_masked_aes_stream_io.sv
// tb_masked_aes_stream_io: scoreboard bench for the masked AES stream front/back end with a behavioural core stub.
module tb_masked_aes_stream_io;
  logic         clk = 1'b0, reset = 1'b0;
  logic         in_valid, in_ready, core_go, core_done, out_valid, out_ready, out_last, busy;
  logic [15:0]  in_pt, in_key, rnd_in, out_data;
  logic [255:0] core_pt, core_key, core_out;
  logic         in_valid3, in_ready3, core_go3, core_done3, out_valid3, out_ready3, out_last3, busy3;
  logic [23:0]  in_pt3, in_key3, out_data3;
  logic [31:0]  rnd3;
  logic [383:0] core_pt3, core_key3, core_out3;
  int           errors = 0, checks = 0;
  logic [7:0]   exp_q[$];
  logic [255:0] exp_pt, exp_key;

  always #5 clk = ~clk;

  masked_aes_stream_io #(.SHARES(2), .LANE_W(8), .BLOCK_W(128)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .rnd_in(rnd_in), .core_go(core_go), .core_pt(core_pt), .core_key(core_key), .core_out(core_out),
    .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  masked_aes_stream_io #(.SHARES(3), .LANE_W(8), .BLOCK_W(128)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .in_pt(in_pt3), .in_key(in_key3),
    .rnd_in(rnd3), .core_go(core_go3), .core_pt(core_pt3), .core_key(core_key3), .core_out(core_out3),
    .core_done(core_done3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3)
  );

  // Core stub: the all-zero block gives the real AES-128 answer, anything else a fixed keyed mix.
  function automatic logic [127:0] stub_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == 128'h0 && key == 128'h0) return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    return pt ^ {key[119:0], key[127:120]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic push_exp(input logic [127:0] ct);
    for (int b = 0; b < 16; b++) exp_q.push_back(ct[127-8*b -: 8]);
  endtask

  task automatic load_block(input logic [127:0] pt, input logic [127:0] key, input bit gaps, input bit spur);
    for (int b = 0; b < 16; b++) begin
      logic [7:0] mp, mk;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_pt = 16'($urandom); in_key = 16'($urandom); rnd_in = 16'($urandom);
        @(negedge clk);
      end
      mp = 8'($urandom); mk = 8'($urandom);
      in_valid = 1'b1; rnd_in = 16'($urandom);
      in_pt  = {mp, pt[127-8*b -: 8] ^ mp};
      in_key = {mk, key[127-8*b -: 8] ^ mk};
      exp_pt[255-8*b -: 8]  = mp; exp_pt[127-8*b -: 8]  = pt[127-8*b -: 8] ^ mp;
      exp_key[255-8*b -: 8] = mk; exp_key[127-8*b -: 8] = key[127-8*b -: 8] ^ mk;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready beat %0d: got %b want 1", b, in_ready); end
      if (spur && b == 5) begin core_done = 1'b1; core_out = {8{$urandom}}; end
      @(negedge clk);
      core_done = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_go();
    checks++; if (core_go !== 1'b1) begin errors++; $display("FAIL go_pulse: got %b want 1", core_go); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_flags: in_ready=%b busy=%b want 0/1", in_ready, busy); end
    checks++; if (core_pt !== exp_pt) begin errors++; $display("FAIL core_pt: got %h want %h", core_pt, exp_pt); end
    checks++; if (core_key !== exp_key) begin errors++; $display("FAIL core_key: got %h want %h", core_key, exp_key); end
  endtask

  task automatic run_core(input bit spur_start, input bit stray_in);
    logic [127:0] ct, m;
    if (spur_start) begin core_done = 1'b1; core_out = {8{$urandom}}; end
    @(negedge clk);
    core_done = 1'b0;
    checks++; if (core_go !== 1'b0) begin errors++; $display("FAIL go_one_cycle: got %b want 0", core_go); end
    repeat (19) begin
      if (stray_in) begin in_valid = 1'b1; in_pt = 16'($urandom); in_key = 16'($urandom); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wait_hold: out_valid got %b want 0", out_valid); end
    checks++; if (core_pt !== exp_pt || core_key !== exp_key) begin errors++; $display("FAIL wait_stable: pt %h key %h", core_pt, core_key); end
    ct = stub_ct(core_pt[127:0] ^ core_pt[255:128], core_key[127:0] ^ core_key[255:128]);
    m  = {$urandom, $urandom, $urandom, $urandom};
    core_out = {m, ct ^ m}; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_latency: out_valid got %b want 1", out_valid); end
  endtask

  task automatic unload_block(input bit bp);
    int n = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [15:0] held = '0;
    logic [7:0] e;
    while (n < 16 && cyc < 200) begin
      if (stalled) begin
        checks++; if (out_data !== held) begin errors++; $display("FAIL stall_stable: got %h want %h", out_data, held); end
      end
      if (out_valid) begin
        out_ready = bp ? (cyc % 2 == 0) : 1'b1;
        if (out_ready) begin
          e = exp_q.pop_front();
          checks++; if ((out_data[7:0] ^ out_data[15:8]) !== e) begin errors++; $display("FAIL lane %0d: got %h want %h", n, out_data[7:0] ^ out_data[15:8], e); end
          checks++; if (out_last !== (n == 15)) begin errors++; $display("FAIL last %0d: got %b want %b", n, out_last, n == 15); end
          n++; stalled = 1'b0;
        end else begin
          held = out_data; stalled = 1'b1;
        end
      end else out_ready = 1'b0;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL unload_timeout: got %0d lanes want 16", n); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL turnaround: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      in_valid = 1'(($urandom)); in_pt = 16'($urandom); in_key = 16'($urandom); rnd_in = 16'($urandom);
      core_done = 1'($urandom); core_out = {8{$urandom}}; out_ready = 1'($urandom);
      @(negedge clk);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if ({out_valid, core_go, busy, out_last} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {out_valid, core_go, busy, out_last}); end
    checks++; if (core_pt !== '0 || core_key !== '0 || out_data !== '0) begin errors++; $display("FAIL rst_data: pt %h key %h out %h want 0", core_pt, core_key, out_data); end
    in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_load();
    push_exp(stub_ct(128'h0, 128'h0));
    load_block(128'h0, 128'h0, 1'b0, 1'b0);
    check_go();
    run_core(1'b0, 1'b0);
    unload_block(1'b0);
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, key;
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    push_exp(stub_ct(pt, key));
    load_block(pt, key, 1'b1, 1'b0);
    check_go();
    run_core(1'b0, 1'b0);
    unload_block(1'b1);
  endtask

  task automatic test_spurious_done();
    logic [127:0] pt, key;
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    push_exp(stub_ct(pt, key));
    load_block(pt, key, 1'b0, 1'b1);
    check_go();
    run_core(1'b1, 1'b1);
    unload_block(1'b0);
  endtask

  task automatic test_reset_mid_wait();
    load_block({$urandom, $urandom, $urandom, $urandom}, 128'h5, 1'b0, 1'b0);
    check_go();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid); end
    checks++; if (core_pt !== '0 || core_key !== '0) begin errors++; $display("FAIL midrst_data: pt %h key %h want 0", core_pt, core_key); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: out_valid=%b in_ready=%b", out_valid, in_ready); end
    push_exp(stub_ct(128'h000102030405060708090a0b0c0d0e0f, 128'h0));
    load_block(128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b0, 1'b0);
    check_go();
    run_core(1'b0, 1'b0);
    unload_block(1'b0);
  endtask

  task automatic test_remask();
    logic [127:0] pt, key;
    logic [383:0] sh_pt, sh_key;
    pt = 128'h00112233445566778899aabbccddeeff; key = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 16; b++) begin
      logic [7:0] p1, p2, k1, k2;
      p1 = 8'($urandom); p2 = 8'($urandom); k1 = 8'($urandom); k2 = 8'($urandom);
      in_pt3  = {p2, p1, pt[127-8*b -: 8] ^ p1 ^ p2};
      in_key3 = {k2, k1, key[127-8*b -: 8] ^ k1 ^ k2};
      for (int i = 0; i < 3; i++) begin
        sh_pt[i*128 + 127 - 8*b -: 8]  = in_pt3[i*8 +: 8];
        sh_key[i*128 + 127 - 8*b -: 8] = in_key3[i*8 +: 8];
      end
      rnd3 = $urandom; in_valid3 = 1'b1;
      @(negedge clk);
    end
    in_valid3 = 1'b0;
    checks++; if (core_go3 !== 1'b1) begin errors++; $display("FAIL s3_go: got %b want 1", core_go3); end
    checks++; if ((core_pt3[127:0] ^ core_pt3[255:128] ^ core_pt3[383:256]) !== pt) begin errors++; $display("FAIL s3_pt_xor: got %h want %h", core_pt3[127:0] ^ core_pt3[255:128] ^ core_pt3[383:256], pt); end
    checks++; if ((core_key3[127:0] ^ core_key3[255:128] ^ core_key3[383:256]) !== key) begin errors++; $display("FAIL s3_key_xor: got %h want %h", core_key3[127:0] ^ core_key3[255:128] ^ core_key3[383:256], key); end
`ifdef MASKED_IO_REMASK_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (core_pt3[i*128 +: 128] === sh_pt[i*128 +: 128]) begin errors++; $display("FAIL s3_pt_share%0d: got %h want a refreshed value", i, core_pt3[i*128 +: 128]); end
      checks++; if (core_key3[i*128 +: 128] === sh_key[i*128 +: 128]) begin errors++; $display("FAIL s3_key_share%0d: got %h want a refreshed value", i, core_key3[i*128 +: 128]); end
    end
`else
    checks++; if (core_pt3 !== sh_pt) begin errors++; $display("FAIL s3_pt_shares: got %h want %h", core_pt3, sh_pt); end
    checks++; if (core_key3 !== sh_key) begin errors++; $display("FAIL s3_key_shares: got %h want %h", core_key3, sh_key); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    in_valid = 1'b0; in_pt = '0; in_key = '0; rnd_in = '0; core_done = 1'b0; core_out = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_pt3 = '0; in_key3 = '0; rnd3 = '0; core_done3 = 1'b0; core_out3 = '0; out_ready3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero_load();
    test_backpressure();
    test_spurious_done();
    test_reset_mid_wait();
    test_remask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
